// File: rtl/sum_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : sum_word_packer
// Brief    : Packs a byte stream into 32-bit little-endian words, buffers
//            them in a small synchronous FIFO with a frame-last marker, and
//            drains them over a valid/ready stream. A sticky flag records
//            words lost to a full FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module sum_word_packer #(
  parameter int DEPTH       = 8,
  parameter int FRAME_WORDS = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_data,
  output logic                     out_last,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_LVL_W = c_PTR_W + 1;
  localparam int c_WC_W  = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

  // Packing state
  logic [1:0]          r_lane;
  logic [23:0]         r_stage;
  logic [c_WC_W-1:0]   r_wcnt;

  // FIFO state: each entry is {last, word}
  logic [32:0]         r_mem [DEPTH];
  logic [c_PTR_W-1:0]  r_wptr;
  logic [c_PTR_W-1:0]  r_rptr;
  logic [c_LVL_W-1:0]  r_level;
  logic                r_overflow;

  logic                w_complete;
  logic                w_pop;
  logic                w_push;
  logic                w_not_full;
  logic                w_last_word;
  logic [31:0]         w_word;
  logic [32:0]         w_head;

  // Word completion, push/pop qualification and head selection
  always_comb begin
    w_complete  = in_valid && (r_lane == 2'd3);
    w_not_full  = (r_level < c_LVL_W'(DEPTH));
    w_pop       = (r_level != '0) && out_ready;
    // A pop on the same edge frees the slot, so a full FIFO can still accept.
    w_push      = w_complete && (w_not_full || w_pop);
    w_last_word = (r_wcnt == c_WC_W'(FRAME_WORDS - 1));
    w_word      = {in_data, r_stage[23:16], r_stage[15:8], r_stage[7:0]};
    w_head      = r_mem[r_rptr];
  end

  // Lane counter, staging register and frame word counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lane  <= 2'd0;
      r_stage <= 24'd0;
      r_wcnt  <= '0;
    end else if (in_valid) begin
      r_lane <= r_lane + 2'd1;
      case (r_lane)
        2'd0:    r_stage[7:0]   <= in_data;
        2'd1:    r_stage[15:8]  <= in_data;
        2'd2:    r_stage[23:16] <= in_data;
        default: r_stage        <= r_stage;
      endcase
      // Counts dropped words too, so frames stay aligned after an overflow.
      if (r_lane == 2'd3) begin
        r_wcnt <= w_last_word ? '0 : r_wcnt + c_WC_W'(1);
      end
    end
  end

  // FIFO storage write port (contents need no reset; level gates the output)
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {w_last_word, w_word};
    end
  end

  // FIFO pointers, occupancy counter and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + c_LVL_W'(1);
      end else if (w_pop && !w_push) begin
        r_level <= r_level - c_LVL_W'(1);
      end
      if (w_complete && !w_push) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Output stream: head entry when non-empty, zero otherwise
  always_comb begin
    out_valid = (r_level != '0);
    out_data  = out_valid ? w_head[31:0] : 32'd0;
    out_last  = out_valid ? w_head[32]   : 1'b0;
    level     = r_level;
    overflow  = r_overflow;
  end

endmodule
`default_nettype wire
